// File: rtl/bist_err_logger.sv
// Multi-channel BIST error logger: per-channel pending capture, round-robin push into a record FIFO,
// sticky status and saturating error count. Optional capture timestamps with BIST_LOG_TIMESTAMP_EN.

module bist_err_lane #(
  parameter int CODE_W = 8
`ifdef BIST_LOG_TIMESTAMP_EN
  , parameter int TS_W = 12
`endif
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              clr,
  input  logic              flag,
  input  logic [CODE_W-1:0] code,
  input  logic              gnt,
`ifdef BIST_LOG_TIMESTAMP_EN
  input  logic [TS_W-1:0]   ts,
  output logic [TS_W-1:0]   pts,
`endif
  output logic              pend,
  output logic [CODE_W-1:0] pcode,
  output logic              ovf
);

  // A slot freed by this edge's grant may be refilled at the same edge; otherwise the first code is kept.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pend  <= 1'b0;
      pcode <= '0;
      ovf   <= 1'b0;
`ifdef BIST_LOG_TIMESTAMP_EN
      pts   <= '0;
`endif
    end else if (clr) begin
      pend  <= 1'b0;
      pcode <= '0;
      ovf   <= 1'b0;
`ifdef BIST_LOG_TIMESTAMP_EN
      pts   <= '0;
`endif
    end else if (flag) begin
      if (!pend || gnt) begin
        pend  <= 1'b1;
        pcode <= code;
`ifdef BIST_LOG_TIMESTAMP_EN
        pts   <= ts;
`endif
      end else begin
        ovf <= 1'b1;
      end
    end else if (gnt) begin
      pend <= 1'b0;
    end
  end

endmodule

module bist_err_logger #(
  parameter int NCH    = 4,
  parameter int CODE_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16,
  parameter int TS_W   = 12,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int LW    = $clog2(DEPTH) + 1,
`ifdef BIST_LOG_TIMESTAMP_EN
  localparam int REC_W = TS_W + CHW + CODE_W
`else
  localparam int REC_W = CHW + CODE_W
`endif
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  clr,
  input  logic [NCH-1:0]        err_flag,
  input  logic [NCH*CODE_W-1:0] err_code,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [REC_W-1:0]      rd_data,
  output logic [LW-1:0]         fifo_lvl,
  output logic                  err_any,
  output logic [NCH-1:0]        ovf,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [NCH-1:0]             pend, gnt;
  logic [NCH-1:0][CODE_W-1:0] pcode;
  logic [CHW-1:0]             rr_ptr, gidx, idx;
  logic                       gnt_any, pop, full, push_ok;
  logic [DEPTH-1:0][REC_W-1:0] mem;
  logic [AW-1:0]              wptr, rptr;
  logic [REC_W-1:0]           rec;
  logic [CHW:0]               pc;
  logic [CNT_W:0]             sum;
  logic [CNT_W-1:0]           cnt_nxt;

`ifdef BIST_LOG_TIMESTAMP_EN
  logic [TS_W-1:0]            ts;
  logic [NCH-1:0][TS_W-1:0]   pts;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)   ts <= '0;
    else if (clr) ts <= '0;
    else          ts <= ts + 1'b1;
  end
`endif

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_lane
      bist_err_lane #(
        .CODE_W(CODE_W)
`ifdef BIST_LOG_TIMESTAMP_EN
        , .TS_W(TS_W)
`endif
      ) u_lane (
        .clk  (clk),
        .res_n(res_n),
        .clr  (clr),
        .flag (err_flag[g]),
        .code (err_code[g*CODE_W +: CODE_W]),
        .gnt  (gnt[g]),
`ifdef BIST_LOG_TIMESTAMP_EN
        .ts   (ts),
        .pts  (pts[g]),
`endif
        .pend (pend[g]),
        .pcode(pcode[g]),
        .ovf  (ovf[g])
      );
    end
  endgenerate

  assign rd_valid = (fifo_lvl != '0);
  assign full     = (fifo_lvl == LW'(DEPTH));
  assign pop      = rd_en && rd_valid;
  assign push_ok  = !full || pop;
  assign rd_data  = rd_valid ? mem[rptr] : '0;

  // Round-robin: first pending channel at or after rr_ptr, cyclically.
  always_comb begin
    gnt_any = 1'b0;
    gidx    = '0;
    idx     = '0;
    gnt     = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = CHW'((int'(rr_ptr) + k) % NCH);
      if (!gnt_any && pend[idx]) begin
        gnt_any = 1'b1;
        gidx    = idx;
      end
    end
    if (!push_ok || clr) gnt_any = 1'b0;
    if (gnt_any) gnt[gidx] = 1'b1;
  end

`ifdef BIST_LOG_TIMESTAMP_EN
  assign rec = {pts[gidx], gidx, pcode[gidx]};
`else
  assign rec = {gidx, pcode[gidx]};
`endif

  always_comb begin
    pc = '0;
    for (int i = 0; i < NCH; i++) pc = pc + (CHW+1)'(err_flag[i]);
    sum     = {1'b0, err_cnt} + (CNT_W+1)'(pc);
    cnt_nxt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (gnt_any) mem[wptr] <= rec;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_lvl <= '0;
      rr_ptr   <= '0;
      err_any  <= 1'b0;
      err_cnt  <= '0;
    end else if (clr) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_lvl <= '0;
      rr_ptr   <= '0;
      err_any  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (gnt_any) begin
        wptr   <= wptr + 1'b1;
        rr_ptr <= (gidx == CHW'(NCH-1)) ? '0 : gidx + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({gnt_any, pop})
        2'b10:   fifo_lvl <= fifo_lvl + 1'b1;
        2'b01:   fifo_lvl <= fifo_lvl - 1'b1;
        default: fifo_lvl <= fifo_lvl;
      endcase
      if (|err_flag) err_any <= 1'b1;
      err_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_bist_err_logger.sv
// Directed bench for bist_err_logger (NCH=4, CODE_W=8, DEPTH=8, CNT_W=16): vector table plus
// hand sequences for full/held/overflow, counter saturation, clear and async reset.
module tb_bist_err_logger;
`ifdef BIST_LOG_TIMESTAMP_EN
  localparam int REC_W = 22;
`else
  localparam int REC_W = 10;
`endif

  logic              clk = 1'b0;
  logic              res_n, clr, rd_en;
  logic [3:0]        err_flag;
  logic [31:0]       err_code;
  logic              rd_valid;
  logic [REC_W-1:0]  rd_data;
  logic [3:0]        fifo_lvl;
  logic              err_any;
  logic [3:0]        ovf;
  logic [15:0]       err_cnt;
  logic [9:0]        rd_rec;

  int checks = 0;
  int failures = 0;

  assign rd_rec = rd_data[9:0];

  bist_err_logger dut (
    .clk(clk), .res_n(res_n), .clr(clr), .err_flag(err_flag), .err_code(err_code),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .fifo_lvl(fifo_lvl),
    .err_any(err_any), .ovf(ovf), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  flag;
    logic [31:0] code;
    logic        rd;
    logic        rv;
    logic [9:0]  data;
    logic [3:0]  lvl;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] f, input logic [31:0] c, input logic rd, input logic cl);
    err_flag = f;
    err_code = c;
    rd_en    = rd;
    clr      = cl;
    @(posedge clk);
    #1;
    err_flag = '0;
    err_code = '0;
    rd_en    = 1'b0;
    clr      = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_rec;
`ifdef BIST_LOG_TIMESTAMP_EN
    logic [11:0] ts1, ts2;
`endif
    // flag, code, rd_en -> rd_valid, rd_data, fifo_lvl, err_cnt
    tbl[0]  = '{4'hF, 32'h13121110, 1'b0, 1'b0, 10'h000, 4'd0, 16'd4};
    tbl[1]  = '{4'h0, 32'h0,        1'b0, 1'b1, 10'h010, 4'd1, 16'd4};
    tbl[2]  = '{4'h0, 32'h0,        1'b0, 1'b1, 10'h010, 4'd2, 16'd4};
    tbl[3]  = '{4'h0, 32'h0,        1'b1, 1'b1, 10'h111, 4'd2, 16'd4};
    tbl[4]  = '{4'h0, 32'h0,        1'b1, 1'b1, 10'h212, 4'd2, 16'd4};
    tbl[5]  = '{4'h0, 32'h0,        1'b1, 1'b1, 10'h313, 4'd1, 16'd4};
    tbl[6]  = '{4'h0, 32'h0,        1'b1, 1'b0, 10'h000, 4'd0, 16'd4};
    tbl[7]  = '{4'h4, 32'h005A0000, 1'b0, 1'b0, 10'h000, 4'd0, 16'd5};
    tbl[8]  = '{4'h0, 32'h0,        1'b0, 1'b1, 10'h25A, 4'd1, 16'd5};
    tbl[9]  = '{4'h0, 32'h0,        1'b1, 1'b0, 10'h000, 4'd0, 16'd5};
    tbl[10] = '{4'h7, 32'h00222120, 1'b0, 1'b0, 10'h000, 4'd0, 16'd8};
    tbl[11] = '{4'h0, 32'h0,        1'b0, 1'b1, 10'h020, 4'd1, 16'd8};
    tbl[12] = '{4'h0, 32'h0,        1'b0, 1'b1, 10'h020, 4'd2, 16'd8};
    tbl[13] = '{4'h0, 32'h0,        1'b0, 1'b1, 10'h020, 4'd3, 16'd8};
    tbl[14] = '{4'h8, 32'h33000000, 1'b0, 1'b1, 10'h020, 4'd3, 16'd9};
    tbl[15] = '{4'h0, 32'h0,        1'b1, 1'b1, 10'h121, 4'd3, 16'd9};
    tbl[16] = '{4'h0, 32'h0,        1'b1, 1'b1, 10'h222, 4'd2, 16'd9};
    tbl[17] = '{4'h0, 32'h0,        1'b1, 1'b1, 10'h333, 4'd1, 16'd9};
    tbl[18] = '{4'h0, 32'h0,        1'b1, 1'b0, 10'h000, 4'd0, 16'd9};
    tbl[19] = '{4'h0, 32'h0,        1'b1, 1'b0, 10'h000, 4'd0, 16'd9};

    res_n = 1'b0; clr = 1'b0; rd_en = 1'b0; err_flag = '0; err_code = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rd_valid", 32'(rd_valid), 0);
    chk("rst.rd_data",  32'(rd_data), 0);
    chk("rst.lvl",      32'(fifo_lvl), 0);
    chk("rst.err_any",  32'(err_any), 0);
    chk("rst.ovf",      32'(ovf), 0);
    chk("rst.cnt",      32'(err_cnt), 0);
    res_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 20; v++) begin
      step(tbl[v].flag, tbl[v].code, tbl[v].rd, 1'b0);
      chk($sformatf("vec%0d.rd_valid", v), 32'(rd_valid), 32'(tbl[v].rv));
      chk($sformatf("vec%0d.rd_data", v),  32'(rd_rec), 32'(tbl[v].data));
      chk($sformatf("vec%0d.lvl", v),      32'(fifo_lvl), 32'(tbl[v].lvl));
      chk($sformatf("vec%0d.cnt", v),      32'(err_cnt), 32'(tbl[v].cnt));
      chk($sformatf("vec%0d.err_any", v),  32'(err_any), 1);
      chk($sformatf("vec%0d.ovf", v),      32'(ovf), 0);
    end

    // Nine rotating events with no pops: eight fill the FIFO, the ninth (ch0) is held.
    for (int k = 0; k < 9; k++)
      step(4'(1 << (k % 4)), 32'(32'h40 + k) << (8 * (k % 4)), 1'b0, 1'b0);
    step(4'h0, 32'h0, 1'b0, 1'b0);
    chk("full.lvl",  32'(fifo_lvl), 8);
    chk("full.head", 32'(rd_rec), 32'h040);
    chk("full.ovf",  32'(ovf), 0);
    step(4'h1, 32'h00000099, 1'b0, 1'b0);
    chk("held.ovf", 32'(ovf), 32'h1);
    chk("held.lvl", 32'(fifo_lvl), 8);
    chk("held.cnt", 32'(err_cnt), 19);
    step(4'h0, 32'h0, 1'b1, 1'b0);
    chk("fullpop.lvl", 32'(fifo_lvl), 8);
    for (int k = 1; k <= 8; k++) begin
      exp_rec = {2'(k % 4), 8'(8'h40 + k)};
      chk($sformatf("drain%0d.head", k), 32'(rd_rec), 32'(exp_rec));
      step(4'h0, 32'h0, 1'b1, 1'b0);
    end
    chk("drain.lvl",   32'(fifo_lvl), 0);
    chk("drain.valid", 32'(rd_valid), 0);

    // Clear wins over same-cycle flags and pops.
    step(4'hF, 32'hFFFFFFFF, 1'b1, 1'b1);
    chk("clr1.cnt", 32'(err_cnt), 0);
    chk("clr1.ovf", 32'(ovf), 0);
    chk("clr1.any", 32'(err_any), 0);
    step(4'h0, 32'h0, 1'b0, 1'b0);
    chk("clr1.lvl_after", 32'(fifo_lvl), 0);

    for (int k = 0; k < 16383; k++) step(4'hF, 32'h01020304, 1'b0, 1'b0);
    step(4'h3, 32'h0, 1'b0, 1'b0);
    chk("sat.fffe", 32'(err_cnt), 32'hFFFE);
    step(4'h7, 32'h0, 1'b0, 1'b0);
    chk("sat.ffff", 32'(err_cnt), 32'hFFFF);
    step(4'h1, 32'h0, 1'b0, 1'b0);
    chk("sat.hold", 32'(err_cnt), 32'hFFFF);
    chk("sat.ovf",  32'(ovf), 32'hF);
    step(4'hF, 32'h0, 1'b1, 1'b1);
    chk("clr2.cnt",   32'(err_cnt), 0);
    chk("clr2.any",   32'(err_any), 0);
    chk("clr2.ovf",   32'(ovf), 0);
    chk("clr2.lvl",   32'(fifo_lvl), 0);
    chk("clr2.valid", 32'(rd_valid), 0);
    step(4'h0, 32'h0, 1'b0, 1'b0);
    chk("clr2.lvl_after", 32'(fifo_lvl), 0);

    // Asynchronous reset with a record queued and another pending.
    step(4'h1, 32'h00000077, 1'b0, 1'b0);
    step(4'h0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst.lvl", 32'(fifo_lvl), 1);
    step(4'h2, 32'h00008800, 1'b0, 1'b0);
    res_n = 1'b0;
    #2;
    chk("arst.valid", 32'(rd_valid), 0);
    chk("arst.data",  32'(rd_data), 0);
    chk("arst.lvl",   32'(fifo_lvl), 0);
    chk("arst.cnt",   32'(err_cnt), 0);
    chk("arst.any",   32'(err_any), 0);
    #1;
    res_n = 1'b1;
    @(posedge clk);
    #1;
    step(4'h0, 32'h0, 1'b0, 1'b0);
    chk("arst.lvl_after", 32'(fifo_lvl), 0);

`ifdef BIST_LOG_TIMESTAMP_EN
    step(4'h0, 32'h0, 1'b0, 1'b1);
    step(4'h2, 32'h00000100, 1'b0, 1'b0);
    repeat (4) step(4'h0, 32'h0, 1'b0, 1'b0);
    step(4'h2, 32'h00000200, 1'b0, 1'b0);
    repeat (3) step(4'h0, 32'h0, 1'b0, 1'b0);
    chk("ts.lvl", 32'(fifo_lvl), 2);
    ts1 = rd_data[21:10];
    step(4'h0, 32'h0, 1'b1, 1'b0);
    ts2 = rd_data[21:10];
    chk("ts.delta", 32'(12'(ts2 - ts1)), 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
